mips_fetch_unit: RTL and testbench

Instruction-fetch stage directly upstream of the MIPS single-cycle datapath. It owns the program counter and fetches 32-bit words from an instruction memory over a req/ack handshake with variable latency. It presents each instruction with valid/ready to the datapath and applies branch/jump redirects that the datapath returns. It also detects memory timeouts and misaligned targets.

---
 rtl/mips_fetch_pkg.sv | 17 +
 rtl/fetch_timeout_counter.sv | 33 +++
 rtl/mips_fetch_unit.sv | 175 +++++++++++++++++
 tb/tb_mips_fetch_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_fetch_pkg.sv
// rtl/mips_fetch_pkg.sv - shared types and constants for the MIPS instruction-fetch stage
package mips_fetch_pkg;

    // Fetch FSM: IDLE waits for fetch_en, REQ owns an outstanding memory
    // request, HOLD presents an instruction to the datapath, ERR is terminal.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        ERR  = 2'd3
    } fetch_state_t;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;

endpackage

// File: rtl/fetch_timeout_counter.sv
// rtl/fetch_timeout_counter.sv - wait-cycle counter that flags a memory timeout
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   clear_i    return the count to zero
//   enable_i   count one more waiting cycle
//   expired_o  the increment of this cycle brings the count to MAX_WAIT
module fetch_timeout_counter #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    logic [7:0] count_q;

    // Flag on the cycle whose increment would reach MAX_WAIT, so the owner can
    // leave its waiting state on that same edge with a registered decision.
    assign expired_o = enable_i && (count_q == 8'(MAX_WAIT - 1));

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            count_q <= 8'd0;
        end else if (enable_i) begin
            count_q <= count_q + 8'd1;
        end
    end

endmodule

// File: rtl/mips_fetch_unit.sv
// rtl/mips_fetch_unit.sv - PC owner and instruction fetcher for the single-cycle MIPS datapath
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   fetch_en                      allows a new fetch to start
//   mem_req/mem_addr              instruction-memory request (held until mem_ack)
//   mem_ack/mem_rdata             memory response
//   instr_valid/instr_ready       instruction handshake to the datapath
//   instr_out/pc_out/pc_plus4     presented instruction, its address, address+4
//   redirect_valid/redirect_pc    branch/jump target from the datapath
//   fetch_error                   sticky timeout / misaligned-target flag
module mips_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_en,
    output logic               mem_req,
    output logic [31:0]        mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [31:0]        pc_out,
    output logic [31:0]        pc_plus4,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               fetch_error
);

    fetch_state_t       state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [31:0]        pc_out_q, pc_out_d;
    logic [31:0]        pc_plus4_q, pc_plus4_d;
    logic               mem_req_q, mem_req_d;
    logic               instr_valid_q, instr_valid_d;
    logic               fetch_error_q, fetch_error_d;
    logic               squash_q, squash_d;
    logic               timeout;
    logic               redirect_bad;

    assign redirect_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

    fetch_timeout_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .clear_i   ((state_q != REQ) || mem_ack),
        .enable_i  ((state_q == REQ) && !mem_ack),
        .expired_o (timeout)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        mem_addr_d    = mem_addr_q;
        instr_d       = instr_q;
        pc_out_d      = pc_out_q;
        pc_plus4_d    = pc_plus4_q;
        mem_req_d     = mem_req_q;
        instr_valid_d = instr_valid_q;
        fetch_error_d = fetch_error_q;
        squash_d      = squash_q;

        if (state_q != ERR && redirect_bad) begin
            // A misaligned target is fatal; pc keeps its last legal value.
            state_d       = ERR;
            mem_req_d     = 1'b0;
            instr_valid_d = 1'b0;
            fetch_error_d = 1'b1;
            squash_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (redirect_valid) pc_d = redirect_pc;
                    if (fetch_en) begin
                        state_d    = REQ;
                        mem_req_d  = 1'b1;
                        mem_addr_d = pc_d;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        if (squash_q) begin
                            // Stale word for a pre-redirect address: drop it and
                            // re-issue from the redirected pc.
                            squash_d = 1'b0;
                            if (redirect_valid) pc_d = redirect_pc;
                            if (fetch_en) begin
                                mem_addr_d = pc_d;
                            end else begin
                                state_d   = IDLE;
                                mem_req_d = 1'b0;
                            end
                        end else begin
                            instr_d       = mem_rdata;
                            pc_out_d      = pc_q;
                            pc_plus4_d    = pc_q + PC_INC;
                            instr_valid_d = 1'b1;
                            mem_req_d     = 1'b0;
                            state_d       = HOLD;
                            pc_d          = redirect_valid ? redirect_pc : pc_q + PC_INC;
                        end
                    end else if (timeout) begin
                        state_d       = ERR;
                        mem_req_d     = 1'b0;
                        fetch_error_d = 1'b1;
                        squash_d      = 1'b0;
                    end else if (redirect_valid) begin
                        // The request stays on the bus; its answer is discarded.
                        pc_d     = redirect_pc;
                        squash_d = 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect_valid) pc_d = redirect_pc;
                    if (instr_ready) begin
                        instr_valid_d = 1'b0;
                        if (fetch_en) begin
                            state_d    = REQ;
                            mem_req_d  = 1'b1;
                            mem_addr_d = pc_d;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            mem_addr_q    <= RESET_PC;
            instr_q       <= '0;
            pc_out_q      <= RESET_PC;
            pc_plus4_q    <= RESET_PC + PC_INC;
            mem_req_q     <= 1'b0;
            instr_valid_q <= 1'b0;
            fetch_error_q <= 1'b0;
            squash_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            mem_addr_q    <= mem_addr_d;
            instr_q       <= instr_d;
            pc_out_q      <= pc_out_d;
            pc_plus4_q    <= pc_plus4_d;
            mem_req_q     <= mem_req_d;
            instr_valid_q <= instr_valid_d;
            fetch_error_q <= fetch_error_d;
            squash_q      <= squash_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr_valid = instr_valid_q;
    assign instr_out   = instr_q;
    assign pc_out      = pc_out_q;
    assign pc_plus4    = pc_plus4_q;
    assign fetch_error = fetch_error_q;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb/tb_mips_fetch_unit.sv - self-checking bench for mips_fetch_unit
module tb_mips_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_error;

    always #5 clk = ~clk;

    mips_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .MAX_WAIT (15)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_out      (instr_out),
        .pc_out         (pc_out),
        .pc_plus4       (pc_plus4),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_error    (fetch_error)
    );

    typedef struct {
        int          lat;
        int          dly;
        logic [31:0] pc;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    localparam int NV = 5;
    vec_t vecs[NV];
    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int mem_lat  = 1;
    int mem_age  = 0;
    bit mem_en   = 1'b1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0005;
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory answers from the outputs visible now, then one clock edge passes.
    task automatic tick();
        if (rst || !mem_en || mem_req !== 1'b1) begin
            mem_ack = 1'b0;
            mem_age = 0;
        end else begin
            mem_age++;
            if (mem_age >= mem_lat) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_word(mem_addr);
                mem_age   = 0;
            end else begin
                mem_ack = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; fetch_en = 1'b0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; mem_en = 1'b1; mem_lat = 1;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic reset_checks();
        check("rst_mem_req",     {31'd0, mem_req},     32'd0);
        check("rst_mem_addr",    mem_addr,             32'h0);
        check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr_out",   instr_out,            32'h0);
        check("rst_pc_out",      pc_out,               32'h0);
        check("rst_pc_plus4",    pc_plus4,             32'h4);
        check("rst_fetch_error", {31'd0, fetch_error}, 32'd0);
    endtask

    task automatic fetch_one(input logic [31:0] pc, input int lat, input int dly);
        exp_t e;
        int   n;
        mem_lat = lat;
        e.pc    = pc;
        e.instr = mem_word(pc);
        sb_q.push_back(e);
        n = 0;
        do begin
            tick();
            n++;
            if (mem_req && !instr_valid) check("req_addr_hold", mem_addr, pc);
        end while (!instr_valid && n < 40);
        check("instr_valid_seen", {31'd0, instr_valid}, 32'd1);
        if (sb_q.size() > 0) e = sb_q.pop_front();
        if (instr_valid) begin
            check("instr_out", instr_out, e.instr);
            check("pc_out",    pc_out,    e.pc);
            check("pc_plus4",  pc_plus4,  e.pc + 32'd4);
            for (int k = 0; k < dly; k++) begin
                tick();
                check("hold_valid", {31'd0, instr_valid}, 32'd1);
                check("hold_instr", instr_out, e.instr);
                check("hold_pc",    pc_out,    e.pc);
            end
        end
    endtask

    task automatic consume();
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("consumed_valid_low", {31'd0, instr_valid}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{lat: 1, dly: 0, pc: 32'h00};
        vecs[1] = '{lat: 3, dly: 4, pc: 32'h04};
        vecs[2] = '{lat: 2, dly: 1, pc: 32'h08};
        vecs[3] = '{lat: 1, dly: 2, pc: 32'h0C};
        vecs[4] = '{lat: 4, dly: 0, pc: 32'h10};
        mem_ack = 1'b0; mem_rdata = 32'h0;

        // Sequential fetches with varied memory latency and datapath stalls.
        do_reset();
        reset_checks();
        fetch_en = 1'b1;
        for (int v = 0; v < NV; v++) begin
            fetch_one(vecs[v].pc, vecs[v].lat, vecs[v].dly);
            if (v == NV - 1) fetch_en = 1'b0;
            consume();
            if (v < NV - 1) begin
                check("next_req",  {31'd0, mem_req}, 32'd1);
                check("next_addr", mem_addr, vecs[v + 1].pc);
            end else begin
                check("idle_no_req", {31'd0, mem_req}, 32'd0);
            end
        end

        // Redirect in HOLD together with instr_ready.
        do_reset();
        fetch_en = 1'b1;
        fetch_one(32'h0, 1, 0); consume();
        fetch_one(32'h4, 2, 0); consume();
        fetch_one(32'h8, 1, 1);
        redirect_valid = 1'b1; redirect_pc = 32'h40; instr_ready = 1'b1;
        tick();
        redirect_valid = 1'b0; instr_ready = 1'b0;
        check("hold_redir_req",  {31'd0, mem_req}, 32'd1);
        check("hold_redir_addr", mem_addr, 32'h40);
        fetch_one(32'h40, 1, 0);
        fetch_en = 1'b0;
        consume();

        // Redirect while a request is outstanding: the late word is squashed.
        do_reset();
        fetch_en = 1'b1;
        fetch_one(32'h0, 1, 0); consume();
        mem_lat = 3;
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        tick();
        redirect_valid = 1'b0;
        check("squash_valid0", {31'd0, instr_valid}, 32'd0);
        tick();
        check("squash_valid1", {31'd0, instr_valid}, 32'd0);
        check("squash_addr_held", mem_addr, 32'h4);
        tick();
        check("squash_valid2", {31'd0, instr_valid}, 32'd0);
        check("squash_reissue_req",  {31'd0, mem_req}, 32'd1);
        check("squash_reissue_addr", mem_addr, 32'h80);
        fetch_one(32'h80, 1, 0);
        fetch_en = 1'b0;
        consume();

        // Memory never answers: timeout on the 16th cycle, sticky until reset.
        do_reset();
        mem_en = 1'b0;
        fetch_en = 1'b1;
        tick();
        for (int k = 1; k <= 15; k++) begin
            check("wait_err_req", {30'd0, fetch_error, mem_req}, 32'b01);
            tick();
        end
        check("timeout_err", {29'd0, fetch_error, mem_req, instr_valid}, 32'b100);
        mem_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100; instr_ready = 1'b1;
        repeat (4) tick();
        check("err_sticky", {29'd0, fetch_error, mem_req, instr_valid}, 32'b100);
        do_reset();
        reset_checks();
        fetch_en = 1'b1;
        fetch_one(32'h0, 1, 0);
        fetch_en = 1'b0;
        consume();

        // Misaligned redirect target.
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'h42;
        tick();
        redirect_valid = 1'b0;
        check("misalign_err", {30'd0, fetch_error, mem_req}, 32'b10);
        fetch_en = 1'b1;
        tick();
        check("misalign_sticky", {30'd0, fetch_error, mem_req}, 32'b10);

        // pc wraps from 0xFFFF_FFFC to 0.
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; fetch_en = 1'b1;
        tick();
        redirect_valid = 1'b0;
        check("wrap_req_addr", mem_addr, 32'hFFFF_FFFC);
        fetch_one(32'hFFFF_FFFC, 2, 0);
        consume();
        check("wrap_next_req",  {31'd0, mem_req}, 32'd1);
        check("wrap_next_addr", mem_addr, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
